// File: rtl/mips_fetch_unit.sv
// mips_fetch_unit: instruction-fetch front end for the bus-based MIPS core.
// Issues single-outstanding reads on a wait-stated instruction bus, buffers
// fetched words in a small prefetch FIFO and presents {pc, instr} to decode
// over a valid/ready handshake. Redirects follow MIPS delay-slot semantics;
// fetching address HALT_ADDR drains the FIFO and then halts the core.
// Ports:
//   clk, reset (sync, active-high), clk_enable (0 = freeze)
//   active             : 1 while running, 0 once halted
//   instr_address/read : bus request (held stable while waitrequest=1)
//   instr_waitrequest  : bus stall; instr_readdata valid on completion
//   dec_valid/ready    : decode handshake; dec_pc/dec_instr = FIFO head
//   redirect_valid/target : taken branch/jump, target[1:0] ignored
module mips_fetch_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'hBFC00000,
  parameter logic [31:0] HALT_ADDR    = 32'h00000000,
  parameter int unsigned FIFO_DEPTH   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_enable,
  output logic        active,
  output logic [31:0] instr_address,
  output logic        instr_read,
  input  logic        instr_waitrequest,
  input  logic [31:0] instr_readdata,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic [31:0] dec_pc,
  output logic [31:0] dec_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target
);
  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

  state_t          state, n_state;
  logic [31:0]     fetch_pc, n_fetch_pc;
  logic [31:0]     fifo_pc    [FIFO_DEPTH];
  logic [31:0]     fifo_instr [FIFO_DEPTH];
  logic [PW-1:0]   rd_ptr, wr_ptr, n_rd, n_wr;
  logic [CW-1:0]   count, n_count;
  logic            discard, n_discard;
  logic            redirect_pending, n_pending;
  logic [31:0]     pending_target, n_target;

  logic            complete, pop, in_flight, keep, issue;
  logic            flush_all, keep_head;
  logic [31:0]     tgt;
  logic            unused_tgt_lsbs;

  assign unused_tgt_lsbs = ^redirect_target[1:0];

  assign active    = (state != HALTED);
  assign dec_valid = (count != '0) && (state != HALTED);
  assign dec_pc    = fifo_pc[rd_ptr];
  assign dec_instr = fifo_instr[rd_ptr];

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(FIFO_DEPTH - 1)) return '0;
    return p + 1'b1;
  endfunction

  always_comb begin
    complete   = instr_read & ~instr_waitrequest;
    pop        = dec_valid & dec_ready;
    in_flight  = instr_read & ~complete;
    keep       = complete & ~discard;
    tgt        = {redirect_target[31:2], 2'b00};
    n_fetch_pc = fetch_pc;
    n_discard  = discard & ~complete;
    n_pending  = redirect_pending;
    n_target   = pending_target;
    flush_all  = 1'b0;
    keep_head  = 1'b0;

    if (keep) begin
      // the delay-slot read of a pending redirect completes: jump now
      if (redirect_pending) begin
        n_fetch_pc = pending_target;
        n_pending  = 1'b0;
      end else begin
        n_fetch_pc = fetch_pc + 32'd4;
      end
    end

    if (redirect_valid && state != HALTED) begin
      if (count != '0) begin
        // delay slot is already buffered (the head, or the word popped now);
        // everything fetched after it, including any read on the bus, is dropped
        flush_all  = pop;
        keep_head  = ~pop;
        keep       = 1'b0;
        n_discard  = in_flight;
        n_pending  = 1'b0;
        n_fetch_pc = tgt;
      end else if (instr_read && !discard) begin
        // the read on the bus is the delay slot
        if (complete) begin
          n_fetch_pc = tgt;
          n_pending  = 1'b0;
        end else begin
          n_pending = 1'b1;
          n_target  = tgt;
        end
      end else if (fetch_pc == HALT_ADDR) begin
        // no delay slot can be fetched from the halt address
        n_fetch_pc = tgt;
        n_pending  = 1'b0;
      end else begin
        // the next read issued is the delay slot
        n_pending = 1'b1;
        n_target  = tgt;
      end
    end

    n_rd    = rd_ptr;
    n_wr    = wr_ptr;
    n_count = count;
    if (flush_all) begin
      n_rd    = ptr_inc(rd_ptr);
      n_wr    = ptr_inc(rd_ptr);
      n_count = '0;
    end else if (keep_head) begin
      n_wr    = ptr_inc(rd_ptr);
      n_count = CW'(1);
    end else begin
      if (pop)  n_rd = ptr_inc(rd_ptr);
      if (keep) n_wr = ptr_inc(wr_ptr);
      n_count = count + CW'(keep) - CW'(pop);
    end

    n_state = state;
    case (state)
      RUN: begin
        if (n_fetch_pc == HALT_ADDR && !in_flight && !n_pending) n_state = DRAIN;
      end
      DRAIN: begin
        if (redirect_valid && tgt != HALT_ADDR) n_state = RUN;
        else if (count == '0 && !redirect_pending) n_state = HALTED;
      end
      default: n_state = HALTED;
    endcase

    issue = (n_state == RUN) && !in_flight && (n_count < CW'(FIFO_DEPTH)) &&
            (n_fetch_pc != HALT_ADDR);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= RUN;
      fetch_pc         <= RESET_VECTOR;
      instr_address    <= RESET_VECTOR;
      instr_read       <= 1'b0;
      rd_ptr           <= '0;
      wr_ptr           <= '0;
      count            <= '0;
      discard          <= 1'b0;
      redirect_pending <= 1'b0;
      pending_target   <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        fifo_pc[i]    <= '0;
        fifo_instr[i] <= '0;
      end
    end else if (clk_enable) begin
      state            <= n_state;
      fetch_pc         <= n_fetch_pc;
      instr_read       <= in_flight | issue;
      if (issue) instr_address <= n_fetch_pc;
      rd_ptr           <= n_rd;
      wr_ptr           <= n_wr;
      count            <= n_count;
      discard          <= n_discard;
      redirect_pending <= n_pending;
      pending_target   <= n_target;
      if (keep) begin
        fifo_pc[wr_ptr]    <= instr_address;
        fifo_instr[wr_ptr] <= instr_readdata;
      end
    end
  end
endmodule

// File: tb/tb_mips_fetch_unit.sv
// Testbench for mips_fetch_unit: cycle table for streaming, stalls,
// back-pressure and clock-enable freeze, then directed redirect/halt sequences.
module tb_mips_fetch_unit;
  localparam logic [31:0] B = 32'hBFC00000;

  logic        clk = 1'b0;
  logic        reset, clk_enable, instr_waitrequest, dec_ready, redirect_valid;
  logic [31:0] redirect_target, instr_readdata;
  logic        active, instr_read, dec_valid;
  logic [31:0] instr_address, dec_pc, dec_instr;

  mips_fetch_unit #(.RESET_VECTOR(32'hBFC00000), .HALT_ADDR(32'h0), .FIFO_DEPTH(2)) dut (
    .clk(clk), .reset(reset), .clk_enable(clk_enable), .active(active),
    .instr_address(instr_address), .instr_read(instr_read),
    .instr_waitrequest(instr_waitrequest), .instr_readdata(instr_readdata),
    .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_pc(dec_pc), .dec_instr(dec_instr),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hDEADBEEF;
  endfunction
  assign instr_readdata = mem_word(instr_address);

  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] popq[$];
  logic        slow = 1'b0;
  int          wcnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // decode-side monitor and "address 0 never requested" guard
  always @(negedge clk) begin
    if (!reset && clk_enable) begin
      if (dec_valid && dec_ready) begin
        popq.push_back(dec_pc);
        check("pop instr", dec_instr, mem_word(dec_pc));
      end
      if (instr_read) check("halt addr fetched", {31'd0, instr_address == 32'h0}, 32'd0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (slow) begin
      if (instr_read && wcnt < 2) begin
        instr_waitrequest = 1'b1;
        wcnt++;
      end else begin
        instr_waitrequest = 1'b0;
        wcnt = 0;
      end
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    redirect_valid = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic wait_pop(input logic [31:0] pc, input string name);
    int unsigned k = 0;
    while (!(dec_valid && dec_ready && dec_pc == pc) && k < 200) begin
      step();
      k++;
    end
    check(name, {31'd0, k < 200}, 32'd1);
  endtask

  task automatic check_stream(input string name, input logic [31:0] e0, input logic [31:0] e1,
                              input logic [31:0] e2, input logic [31:0] never);
    int hits = 0;
    check({name, " enough pops"}, {31'd0, popq.size() >= 3}, 32'd1);
    foreach (popq[i]) if (popq[i] == never) hits++;
    while (popq.size() < 3) popq.push_back(32'hFFFFFFFF);
    check({name, " pop0"}, popq[0], e0);
    check({name, " pop1"}, popq[1], e1);
    check({name, " pop2"}, popq[2], e2);
    check({name, " flushed pc absent"}, hits, 0);
  endtask

  typedef struct {
    logic        w, r, en;
    logic        rd;
    logic [31:0] addr;
    logic        dv;
    logic [31:0] pc;
  } vec_t;

  function automatic vec_t mk(input logic w, input logic r, input logic en, input logic rd,
                              input logic [31:0] addr, input logic dv, input logic [31:0] pc);
    vec_t v;
    v.w = w; v.r = r; v.en = en; v.rd = rd; v.addr = addr; v.dv = dv; v.pc = pc;
    return v;
  endfunction

  vec_t vec[24];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // per-cycle table starting the first cycle after reset release
    vec[0]  = mk(0, 1, 1, 0, B,      0, 0);
    vec[1]  = mk(0, 1, 1, 1, B,      0, 0);
    vec[2]  = mk(1, 1, 1, 1, B + 4,  1, B);
    vec[3]  = mk(1, 1, 1, 1, B + 4,  0, 0);
    vec[4]  = mk(1, 1, 1, 1, B + 4,  0, 0);
    vec[5]  = mk(0, 1, 1, 1, B + 4,  0, 0);
    vec[6]  = mk(0, 1, 1, 1, B + 8,  1, B + 4);
    vec[7]  = mk(0, 0, 1, 1, B + 12, 1, B + 8);
    vec[8]  = mk(0, 0, 1, 0, B + 12, 1, B + 8);
    vec[9]  = mk(0, 0, 1, 0, B + 12, 1, B + 8);
    vec[10] = mk(0, 1, 1, 0, B + 12, 1, B + 8);
    vec[11] = mk(0, 1, 1, 1, B + 16, 1, B + 12);
    vec[12] = mk(0, 1, 1, 1, B + 20, 1, B + 16);
    vec[13] = mk(1, 1, 1, 1, B + 24, 1, B + 20);
    vec[14] = mk(1, 1, 0, 1, B + 24, 0, 0);
    vec[15] = mk(1, 1, 0, 1, B + 24, 0, 0);
    vec[16] = mk(1, 1, 0, 1, B + 24, 0, 0);
    vec[17] = mk(1, 1, 0, 1, B + 24, 0, 0);
    vec[18] = mk(1, 1, 0, 1, B + 24, 0, 0);
    vec[19] = mk(0, 1, 1, 1, B + 24, 0, 0);
    vec[20] = mk(0, 1, 0, 1, B + 28, 1, B + 24);
    vec[21] = mk(0, 1, 0, 1, B + 28, 1, B + 24);
    vec[22] = mk(0, 1, 1, 1, B + 28, 1, B + 24);
    vec[23] = mk(0, 1, 1, 1, B + 32, 1, B + 28);

    clk_enable = 1'b1; instr_waitrequest = 1'b0; dec_ready = 1'b1;
    redirect_valid = 1'b0; redirect_target = '0; reset = 1'b1;
    do_reset();

    check("rst instr_read", instr_read, 0);
    check("rst instr_address", instr_address, B);
    check("rst dec_valid", dec_valid, 0);
    check("rst dec_pc", dec_pc, 0);
    check("rst dec_instr", dec_instr, 0);
    check("rst active", active, 1);

    // T1/T2/T3/T6
    foreach (vec[i]) begin
      instr_waitrequest = vec[i].w;
      dec_ready = vec[i].r;
      clk_enable = vec[i].en;
      check($sformatf("vec%0d instr_read", i), instr_read, vec[i].rd);
      check($sformatf("vec%0d instr_address", i), instr_address, vec[i].addr);
      check($sformatf("vec%0d dec_valid", i), dec_valid, vec[i].dv);
      if (vec[i].dv) begin
        check($sformatf("vec%0d dec_pc", i), dec_pc, vec[i].pc);
        check($sformatf("vec%0d dec_instr", i), dec_instr, mem_word(vec[i].pc));
      end
      step();
    end
    clk_enable = 1'b1; instr_waitrequest = 1'b0; dec_ready = 1'b1;

    // T4: redirect in the cycle that pops the delay slot
    do_reset();
    wait_pop(B + 16, "t4 reach branch");
    step();
    popq.delete();
    redirect_valid = 1'b1; redirect_target = B + 32'h100;
    step();
    redirect_valid = 1'b0;
    repeat (8) step();
    check_stream("t4", B + 20, B + 32'h100, B + 32'h104, B + 24);

    // T4a: delay slot held at the FIFO head during the redirect
    do_reset();
    wait_pop(B + 16, "t4a reach branch");
    step();
    popq.delete();
    dec_ready = 1'b0;
    redirect_valid = 1'b1; redirect_target = B + 32'h101;
    step();
    redirect_valid = 1'b0;
    check("t4a head kept", dec_pc, B + 20);
    step();
    step();
    check("t4a head stable", dec_pc, B + 20);
    check("t4a head valid", dec_valid, 1);
    dec_ready = 1'b1;
    repeat (8) step();
    check_stream("t4a", B + 20, B + 32'h100, B + 32'h104, B + 24);

    // T4b: FIFO empty, delay slot still on the stalled bus; second redirect wins
    do_reset();
    slow = 1'b1;
    wait_pop(B + 16, "t4b reach branch");
    step();
    popq.delete();
    redirect_valid = 1'b1; redirect_target = B + 32'h200;
    step();
    redirect_target = B + 32'h100;
    step();
    redirect_valid = 1'b0;
    repeat (20) step();
    check_stream("t4b", B + 20, B + 32'h100, B + 32'h104, B + 32'h200);
    slow = 1'b0; instr_waitrequest = 1'b0;

    // T5: jump to address 0 with the delay slot buffered, then drain and halt
    do_reset();
    wait_pop(B + 8, "t5 reach branch");
    step();
    popq.delete();
    dec_ready = 1'b0;
    redirect_valid = 1'b1; redirect_target = 32'h0;
    step();
    redirect_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("t5 active while draining", active, 1);
      check("t5 delay slot at head", dec_pc, B + 12);
      check("t5 no request", instr_read, 0);
      step();
    end
    dec_ready = 1'b1;
    begin
      int unsigned k = 0;
      while (active && k < 10) begin
        step();
        k++;
      end
      check("t5 active falls", {31'd0, k < 10}, 32'd1);
    end
    check("t5 delay slot count", popq.size(), 1);
    if (popq.size() > 0) check("t5 delay slot pc", popq[0], B + 12);
    repeat (5) begin
      step();
      check("t5 halted active", active, 0);
      check("t5 halted dec_valid", dec_valid, 0);
      check("t5 halted instr_read", instr_read, 0);
    end
    popq.delete();
    do_reset();
    check("t5 reset active", active, 1);
    check("t5 reset address", instr_address, B);
    step();
    check("t5 restart read", instr_read, 1);
    check("t5 restart address", instr_address, B);
    repeat (4) step();
    if (popq.size() == 0) popq.push_back(32'hFFFFFFFF);
    check("t5 restart first pop", popq[0], B);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
